// File: rtl/click_value_ctrl_if.sv
// Button levels in, edited value and strobes out.
interface click_value_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             btn_inc;
    logic             btn_dec;
    logic             btn_clr;
    logic [WIDTH-1:0] value;
    logic             step_pulse;
    logic             repeating;

    modport master (
        output btn_inc,
        output btn_dec,
        output btn_clr,
        input  value,
        input  step_pulse,
        input  repeating
    );

    modport slave (
        input  btn_inc,
        input  btn_dec,
        input  btn_clr,
        output value,
        output step_pulse,
        output repeating
    );
endinterface

// File: rtl/click_value_ctrl.sv
// Inc/dec/clr button controller with single-step and auto-repeat edits.
// One shared counter times both the hold delay and the repeat period.
module click_value_ctrl #(
    parameter int WIDTH         = 8,
    parameter int HOLD_DELAY    = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter bit WRAP          = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    click_value_ctrl_if.slave bus
);

    localparam int MAX_CNT =
        (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CW =
        (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] V_MAX = '1;
    localparam logic [WIDTH-1:0] V_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dir_up, dir_up_n;
    logic [WIDTH-1:0] value_q, value_n;
    logic             pulse_q, pulse_n;
    logic             rep_q;
    logic             prev_inc, prev_dec, prev_clr;

    logic          rise_inc, rise_dec, rise_clr;
    logic          held, opp;
    logic          do_step, step_up;
    logic [CW-1:0] term;

    assign rise_inc = bus.btn_inc & ~prev_inc;
    assign rise_dec = bus.btn_dec & ~prev_dec;
    assign rise_clr = bus.btn_clr & ~prev_clr;

    assign held = dir_up ? bus.btn_inc : bus.btn_dec;
    assign opp  = dir_up ? bus.btn_dec : bus.btn_inc;
    assign term = (state == HOLD) ? HOLD_TC : REP_TC;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dir_up_n = dir_up;
        value_n  = value_q;
        pulse_n  = 1'b0;
        do_step  = 1'b0;
        step_up  = dir_up;

        unique case (state)
            IDLE: begin
                if (rise_clr) begin
                    value_n = '0;
                    pulse_n = (value_q != '0);
                    state_n = LOCK;
                end else if ((rise_inc | rise_dec) &&
                             bus.btn_inc && bus.btn_dec) begin
                    state_n = LOCK;
                end else if (rise_inc) begin
                    do_step  = 1'b1;
                    step_up  = 1'b1;
                    dir_up_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = HOLD;
                end else if (rise_dec) begin
                    do_step  = 1'b1;
                    step_up  = 1'b0;
                    dir_up_n = 1'b0;
                    cnt_n    = '0;
                    state_n  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                // release and conflict win over a step due this cycle
                if (!held) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (opp || bus.btn_clr) begin
                    cnt_n   = '0;
                    state_n = LOCK;
                end else if (cnt == term) begin
                    do_step = 1'b1;
                    cnt_n   = '0;
                    state_n = REPEAT;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            LOCK: begin
                if (!bus.btn_inc && !bus.btn_dec && !bus.btn_clr) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_step) begin
            if (step_up) begin
                if (value_q != V_MAX) begin
                    value_n = value_q + V_ONE;
                    pulse_n = 1'b1;
                end else if (WRAP) begin
                    value_n = '0;
                    pulse_n = 1'b1;
                end
            end else begin
                if (value_q != '0) begin
                    value_n = value_q - V_ONE;
                    pulse_n = 1'b1;
                end else if (WRAP) begin
                    value_n = V_MAX;
                    pulse_n = 1'b1;
                end
            end
        end
    end

    // prev levels reset high so a button held through reset is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dir_up   <= 1'b1;
            value_q  <= '0;
            pulse_q  <= 1'b0;
            rep_q    <= 1'b0;
            prev_inc <= 1'b1;
            prev_dec <= 1'b1;
            prev_clr <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dir_up   <= dir_up_n;
            value_q  <= value_n;
            pulse_q  <= pulse_n;
            rep_q    <= (state_n == REPEAT);
            prev_inc <= bus.btn_inc;
            prev_dec <= bus.btn_dec;
            prev_clr <= bus.btn_clr;
        end
    end

    assign bus.value      = value_q;
    assign bus.step_pulse = pulse_q;
    assign bus.repeating  = rep_q;

endmodule

// File: tb/tb_click_value_ctrl.sv
// Directed bench: WIDTH=4, HOLD_DELAY=4, REPEAT_PERIOD=2.
// Instance a wraps, instance b saturates.
module tb_click_value_ctrl;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    click_value_ctrl_if #(.WIDTH(4)) ifa ();
    click_value_ctrl_if #(.WIDTH(4)) ifb ();

    click_value_ctrl #(
        .WIDTH(4),
        .HOLD_DELAY(4),
        .REPEAT_PERIOD(2),
        .WRAP(1'b1)
    ) u_a (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifa)
    );

    click_value_ctrl #(
        .WIDTH(4),
        .HOLD_DELAY(4),
        .REPEAT_PERIOD(2),
        .WRAP(1'b0)
    ) u_b (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic check_a(
        input string      tag,
        input logic [3:0] v,
        input logic       p,
        input logic       r
    );
        check({tag, ".value"}, 32'(ifa.value), 32'(v));
        check({tag, ".pulse"}, 32'(ifa.step_pulse), 32'(p));
        check({tag, ".rep"}, 32'(ifa.repeating), 32'(r));
    endtask

    int lh_val [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
    logic       exp_p;
    logic       is_step;
    logic [3:0] exp_v;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifa.btn_inc = 1'b1;
        ifa.btn_dec = 1'b0;
        ifa.btn_clr = 1'b0;
        ifb.btn_inc = 1'b0;
        ifb.btn_dec = 1'b0;
        ifb.btn_clr = 1'b0;

        // reset, with inc held through deassertion
        cyc();
        check_a("reset", 4'd0, 1'b0, 1'b0);
        check("reset_b.value", 32'(ifb.value), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_a("held_thru_reset", 4'd0, 1'b0, 1'b0);
        end
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();

        // short press
        ifa.btn_inc = 1'b1;
        cyc();
        check_a("short.1", 4'd1, 1'b1, 1'b0);
        cyc();
        check_a("short.2", 4'd1, 1'b0, 1'b0);
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();
        check_a("short.idle", 4'd1, 1'b0, 1'b0);

        // clear from 1
        ifa.btn_clr = 1'b1;
        cyc();
        check_a("clr_nz", 4'd0, 1'b1, 1'b0);
        ifa.btn_clr = 1'b0;
        cyc();
        cyc();

        // long hold for 12 cycles
        ifa.btn_inc = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            exp_p = (i == 1) || (i >= 5 && (i % 2) == 1);
            check_a($sformatf("long.%0d", i),
                    4'(lh_val[i-1]), exp_p, (i >= 5));
        end
        ifa.btn_inc = 1'b0;
        cyc();
        check_a("long.rel", 4'd5, 1'b0, 1'b0);
        cyc();

        // wrap both directions
        ifa.btn_clr = 1'b1;
        cyc();
        check_a("clr5", 4'd0, 1'b1, 1'b0);
        ifa.btn_clr = 1'b0;
        cyc();
        cyc();
        ifa.btn_dec = 1'b1;
        cyc();
        check_a("wrap_dec", 4'd15, 1'b1, 1'b0);
        ifa.btn_dec = 1'b0;
        cyc();
        cyc();
        ifa.btn_inc = 1'b1;
        cyc();
        check_a("wrap_inc", 4'd0, 1'b1, 1'b0);
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();

        // saturating instance
        ifb.btn_dec = 1'b1;
        cyc();
        check("sat_dec0.value", 32'(ifb.value), 32'd0);
        check("sat_dec0.pulse", 32'(ifb.step_pulse), 32'd0);
        ifb.btn_dec = 1'b0;
        cyc();
        cyc();
        exp_v = 4'd0;
        ifb.btn_inc = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            is_step = (i == 1) || (i >= 5 && (i % 2) == 1);
            exp_p = 1'b0;
            if (is_step && exp_v != 4'd15) begin
                exp_v = exp_v + 4'd1;
                exp_p = 1'b1;
            end
            check($sformatf("sat.%0d.value", i),
                  32'(ifb.value), 32'(exp_v));
            check($sformatf("sat.%0d.pulse", i),
                  32'(ifb.step_pulse), 32'(exp_p));
        end
        ifb.btn_inc = 1'b0;
        cyc();
        cyc();
        ifb.btn_inc = 1'b1;
        cyc();
        check("sat_inc15.value", 32'(ifb.value), 32'd15);
        check("sat_inc15.pulse", 32'(ifb.step_pulse), 32'd0);
        ifb.btn_inc = 1'b0;
        cyc();
        cyc();
        ifb.btn_dec = 1'b1;
        cyc();
        check("sat_dec15.value", 32'(ifb.value), 32'd14);
        check("sat_dec15.pulse", 32'(ifb.step_pulse), 32'd1);
        ifb.btn_dec = 1'b0;
        cyc();
        cyc();

        // conflict during HOLD
        ifa.btn_inc = 1'b1;
        cyc();
        check_a("conf.press", 4'd1, 1'b1, 1'b0);
        cyc();
        ifa.btn_dec = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check_a("conf.lock", 4'd1, 1'b0, 1'b0);
        end
        ifa.btn_inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_a("conf.dec_only", 4'd1, 1'b0, 1'b0);
        end
        ifa.btn_dec = 1'b0;
        cyc();
        ifa.btn_inc = 1'b1;
        cyc();
        check_a("conf.after", 4'd2, 1'b1, 1'b0);
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();

        // reach 9, then clr together with inc
        ifa.btn_inc = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        check_a("to9", 4'd9, 1'b1, 1'b1);
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();
        ifa.btn_inc = 1'b1;
        ifa.btn_clr = 1'b1;
        cyc();
        check_a("clr_inc", 4'd0, 1'b1, 1'b0);
        ifa.btn_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check_a("clr_lock", 4'd0, 1'b0, 1'b0);
        end
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();
        ifa.btn_clr = 1'b1;
        cyc();
        check_a("clr_zero", 4'd0, 1'b0, 1'b0);
        ifa.btn_clr = 1'b0;
        cyc();
        cyc();
        ifa.btn_inc = 1'b1;
        cyc();
        check_a("post_clr", 4'd1, 1'b1, 1'b0);
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();

        // asynchronous reset mid-REPEAT
        ifa.btn_inc = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check_a("pre_rst", 4'd3, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 4'd0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_a("rst_held", 4'd0, 1'b0, 1'b0);
        end
        ifa.btn_inc = 1'b0;
        cyc();
        cyc();
        ifa.btn_inc = 1'b1;
        cyc();
        check_a("rst_repress", 4'd1, 1'b1, 1'b0);
        ifa.btn_inc = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
